// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch front end.
package inst_fetch_unit_pkg;
  localparam logic [31:0] BUBBLE       = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_fetch_unit_rsv_queue.sv
// In-order reservation ring: slots are reserved at grant, filled on response, popped by decode.
module fetch_rsv_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_rsv,
  input  logic [31:0]                i_rsv_pc,
  input  logic                       i_fill,
  input  logic [31:0]                i_fill_inst,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_head_vld,
  output fetch_ent_t                 o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][31:0] r_pc;
  logic [DEPTH-1:0][31:0] r_inst;
  logic [DEPTH-1:0]       r_filled;
  logic [PW-1:0]          r_wr_ptr, r_fill_ptr, r_hd_ptr;
  logic [CW-1:0]          r_count;

  // Reserve, fill and pop always target distinct slots, so all three may land in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_inst     <= '0;
      r_filled   <= '0;
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_hd_ptr   <= '0;
      r_count    <= '0;
    end else if (i_flush) begin
      r_filled   <= '0;
      r_wr_ptr   <= '0;
      r_fill_ptr <= '0;
      r_hd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (i_rsv) begin
        r_pc[r_wr_ptr]     <= i_rsv_pc;
        r_filled[r_wr_ptr] <= 1'b0;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (i_fill) begin
        r_inst[r_fill_ptr]   <= i_fill_inst;
        r_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr           <= r_fill_ptr + 1'b1;
      end
      if (i_pop) begin
        r_filled[r_hd_ptr] <= 1'b0;
        r_hd_ptr           <= r_hd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(i_rsv) - CW'(i_pop);
    end
  end

  assign o_count     = r_count;
  assign o_head_vld  = r_filled[r_hd_ptr];
  assign o_head.pc   = r_pc[r_hd_ptr];
  assign o_head.inst = r_inst[r_hd_ptr];
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: owns the fetch PC, issues imem reads, drops wrong-path responses after redirects.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = DEF_RESET_PC,
  parameter int          MAX_OUTSTANDING = 2
)(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW-1:0] MAXO_C  = OW'(MAX_OUTSTANDING);

  logic [31:0]   r_fetch_pc;
  logic [OW-1:0] r_out, r_drop;
  logic [CW-1:0] w_count;
  logic          w_head_vld, w_req, w_issue, w_rv_ok, w_fill, w_pop;
  fetch_ent_t    w_head;

  assign w_req     = !redirect_valid && (w_count < DEPTH_C) && (r_out < MAXO_C) && (r_drop == '0);
  assign imem_req  = w_req && !reset;
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol violation and is ignored.
  assign w_rv_ok   = imem_rvalid && (r_out != '0);
  assign w_fill    = w_rv_ok && (r_drop == '0);

  assign if_valid  = w_head_vld && !redirect_valid;
  assign w_pop     = if_valid && if_ready;
  assign if_pc     = if_valid ? w_head.pc   : 32'h0;
  assign if_inst   = if_valid ? w_head.inst : BUBBLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_out <= r_out + OW'(w_issue) - OW'(w_rv_ok);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the wrong path.
        r_fetch_pc <= word_align(redirect_target);
        r_drop     <= r_out - OW'(w_rv_ok);
      end else begin
        if (w_issue)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if ((r_drop != '0) && w_rv_ok)
          r_drop <= r_drop - 1'b1;
      end
    end
  end

  fetch_rsv_queue #(.DEPTH(DEPTH)) u_rsvq (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (redirect_valid),
    .i_rsv       (w_issue),
    .i_rsv_pc    (r_fetch_pc),
    .i_fill      (w_fill),
    .i_fill_inst (imem_rdata),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_vld  (w_head_vld),
    .o_head      (w_head)
  );

  a_rvalid_orphan: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (r_out == '0)));
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: in-order memory model, stream-level scoreboard, directed vectors.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b0, reset = 1'b1;
  logic imem_req, imem_gnt, imem_rvalid, redirect_valid, if_valid, if_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_target, if_pc, if_inst;

  always #5 clk = ~clk;

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic ready; logic req; logic [31:0] addr; logic valid; logic [31:0] pc; } vec_t;

  pend_t pend[$];
  int last_due, cyc, checks, failures, n_out, live, npops;
  int gnt_pct, lat_lo, lat_hi;
  logic t_ready, t_redir;
  logic [31:0] t_tgt, exp_pc, exp_addr;
  logic s_req, s_valid, s_pop;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    last_due = 0; n_out = 0; live = 0;
    exp_pc = RPC; exp_addr = RPC;
  endtask

  // One clock: drive at negedge, sample 1 time unit later, update the stream model.
  task automatic step();
    int lat;
    logic rv, g;
    @(negedge clk);
    if_ready        = t_ready;
    redirect_valid  = t_redir;
    redirect_target = t_tgt;
    imem_gnt        = ($urandom_range(99) < gnt_pct);
    rv = 1'b0; g = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      imem_rdata = inst_of(pend[0].addr);
      void'(pend.pop_front());
    end else imem_rdata = $urandom();
    imem_rvalid = rv;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_pc = if_pc; s_inst = if_inst; s_pop = if_valid && if_ready;
    if (t_redir) begin
      chk("req_in_redirect", s_req, 0);
      chk("valid_in_redirect", s_valid, 0);
      exp_pc = {t_tgt[31:2], 2'b00};
      exp_addr = exp_pc;
      live = 0;
    end else begin
      if (s_req) chk("req_addr", s_addr, exp_addr);
      if (s_req && imem_gnt) begin
        g = 1'b1;
        checks++;
        if (n_out >= MAXO || live >= DEPTH) begin
          failures++;
          $display("FAIL issue_limit: outstanding %0d live %0d, limits %0d/%0d", n_out, live, MAXO, DEPTH);
        end
        lat = $urandom_range(lat_hi, lat_lo);
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        pend.push_back('{s_addr, last_due});
        exp_addr += 4;
        live++;
      end
      if (s_pop) begin
        chk("pop_pc", s_pc, exp_pc);
        chk("pop_inst", s_inst, inst_of(exp_pc));
        exp_pc += 4;
        live--;
        npops++;
      end
    end
    n_out = n_out + int'(g) - int'(rv);
    t_redir = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1; imem_rvalid = 1'b0; imem_gnt = 1'b0; redirect_valid = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[11];
    logic seen;
    tv[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tv[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tv[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
    tv[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
    tv[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
    tv[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h4};
    tv[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h8};
    tv[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'hC};
    tv[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

    checks = 0; failures = 0; cyc = 0; npops = 0;
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    t_ready = 1'b1; t_redir = 1'b0; t_tgt = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_target = 0; if_ready = 0;
    model_reset();

    // Reset state
    #2;
    chk("rst_valid", if_valid, 0);
    chk("rst_inst", if_inst, BUBBLE);
    chk("rst_pc", if_pc, 0);
    chk("rst_req", imem_req, 0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;

    // Streaming at full rate: one instruction per cycle from the third cycle on
    repeat (20) step();
    chk("t1_pop_count", npops, 18);

    // Stall then drain (cycle-exact vectors)
    do_reset();
    for (int i = 0; i < 11; i++) begin
      t_ready = tv[i].ready;
      step();
      chk("vec_req", s_req, tv[i].req);
      if (tv[i].req) chk("vec_addr", s_addr, tv[i].addr);
      chk("vec_valid", s_valid, tv[i].valid);
      if (tv[i].valid) chk("vec_pc", s_pc, tv[i].pc);
    end

    // Redirect with two in flight, latency 3: both responses dropped
    do_reset();
    t_ready = 1'b1; lat_lo = 3; lat_hi = 3;
    step(); step();
    t_redir = 1'b1; t_tgt = 32'h100;
    step();
    step(); chk("t3_drop1_req", s_req, 0);
    step(); chk("t3_drop2_req", s_req, 0);
    step(); chk("t3_resume_req", s_req, 1); chk("t3_resume_addr", s_addr, 32'h100);
    npops = 0;
    repeat (10) step();
    chk("t3_progress", npops > 0, 1);

    // Redirect coinciding with a response: only one left to drop, target realigned
    do_reset();
    lat_lo = 2; lat_hi = 2;
    step(); step();
    t_redir = 1'b1; t_tgt = 32'h203;
    step();
    step(); chk("t4_drop_req", s_req, 0);
    step(); chk("t4_resume_req", s_req, 1); chk("t4_resume_addr", s_addr, 32'h200);

    // Back-to-back redirects: only the second stream is presented
    do_reset();
    repeat (3) step();
    t_redir = 1'b1; t_tgt = 32'h40; step();
    t_redir = 1'b1; t_tgt = 32'h80; step();
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      step();
      if (s_pop && s_pc == 32'h80) seen = 1'b1;
    end
    chk("t5_reach_80", seen, 1);

    // Randomized traffic, stalls and redirects (some near the 2^32 wrap)
    do_reset();
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    for (int k = 0; k < 400; k++) begin
      t_ready = ($urandom_range(99) < 75);
      if ($urandom_range(19) == 0) begin
        t_redir = 1'b1;
        t_tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
      end
      step();
    end
    t_ready = 1'b1; gnt_pct = 100; npops = 0;
    repeat (30) step();
    chk("rand_drain_progress", npops > 0, 1);

    // Asynchronous reset mid-cycle with a full queue
    do_reset();
    t_ready = 1'b0; lat_lo = 1; lat_hi = 1;
    repeat (8) step();
    #2;
    chk("t6_full_valid", if_valid, 1);
    chk("t6_full_req", imem_req, 0);
    #1;
    reset = 1'b1; imem_rvalid = 1'b0;
    #1;
    chk("t6_async_valid", if_valid, 0);
    chk("t6_async_inst", if_inst, BUBBLE);
    chk("t6_async_req", imem_req, 0);
    chk("t6_async_pc", if_pc, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    t_ready = 1'b1;
    step();
    chk("t6_first_req", s_req, 1);
    chk("t6_first_addr", s_addr, RPC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
